// File: rtl/spi_bus_bridge.sv
// SPI-to-bus command sequencer: decodes chip-select framed byte streams into
// auto-incrementing 8-bit bus reads/writes and returns read data to the slave TX register.
module spi_bus_bridge #(
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_cs,
  input  logic              spi_valid,
  input  logic              spi_first,
  input  logic [7:0]        spi_rx,
  output logic [7:0]        spi_tx,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [7:0]        bus_wdata,
  input  logic [7:0]        bus_rdata,
  input  logic              bus_ack,
  output logic              err_overrun,
  output logic              busy
);

  typedef enum logic [2:0] {IDLE, ADDR, WDATA, RDATA, BUSW, BUSR} state_t;

  state_t            state, state_a, state_n;
  logic              rw, rw_n;
  logic [ADDR_W-1:0] addr, addr_a, addr_n;
  logic              req_a, req_n, we_n, ovr_n;
  logic [ADDR_W-1:0] baddr_n;
  logic [7:0]        wdata_n, tx_n;
  logic              cs_meta, cs_s, cs_s_d, cs_fall;
  logic [14:0]       cmd_full;

  assign cs_fall  = cs_s_d & ~cs_s;
  // High address bits from the command byte, left-aligned above the low byte.
  assign cmd_full = {spi_rx[6:0], 8'h00};

  always_comb begin
    state_a = state;
    addr_a  = addr;
    req_a   = bus_req;
    tx_n    = spi_tx;
    if (bus_req && bus_ack) begin
      req_a = 1'b0;
      if (!bus_we) tx_n = bus_rdata;
      if (state == BUSW) begin
        state_a = WDATA;
        addr_a  = addr + ADDR_W'(1);
      end else if (state == BUSR) begin
        state_a = RDATA;
        addr_a  = addr + ADDR_W'(1);
      end
    end

    // The byte is evaluated against the post-ack view of the machine.
    state_n = state_a;
    addr_n  = addr_a;
    req_n   = req_a;
    rw_n    = rw;
    we_n    = bus_we;
    baddr_n = bus_addr;
    wdata_n = bus_wdata;
    ovr_n   = err_overrun;
    if (spi_valid) begin
      if (spi_first) begin
        state_n = ADDR;
        rw_n    = spi_rx[7];
        addr_n  = cmd_full[ADDR_W-1:0];
      end else if (req_a) begin
        ovr_n = 1'b1;
      end else begin
        case (state_a)
          ADDR: begin
            addr_n = (addr_a & ~ADDR_W'(8'hFF)) | ADDR_W'(spi_rx);
            if (rw) begin
              req_n   = 1'b1;
              we_n    = 1'b0;
              baddr_n = (addr_a & ~ADDR_W'(8'hFF)) | ADDR_W'(spi_rx);
              state_n = BUSR;
            end else begin
              state_n = WDATA;
            end
          end
          WDATA: begin
            req_n   = 1'b1;
            we_n    = 1'b1;
            baddr_n = addr_a;
            wdata_n = spi_rx;
            state_n = BUSW;
          end
          RDATA: begin
            req_n   = 1'b1;
            we_n    = 1'b0;
            baddr_n = addr_a;
            state_n = BUSR;
          end
          default: ;
        endcase
      end
    end
    if (cs_fall) state_n = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_meta     <= 1'b0;
      cs_s        <= 1'b0;
      cs_s_d      <= 1'b0;
      state       <= IDLE;
      rw          <= 1'b0;
      addr        <= '0;
      spi_tx      <= 8'h00;
      bus_req     <= 1'b0;
      bus_we      <= 1'b0;
      bus_addr    <= '0;
      bus_wdata   <= 8'h00;
      err_overrun <= 1'b0;
      busy        <= 1'b0;
    end else begin
      cs_meta     <= spi_cs;
      cs_s        <= cs_meta;
      cs_s_d      <= cs_s;
      state       <= state_n;
      rw          <= rw_n;
      addr        <= addr_n;
      spi_tx      <= tx_n;
      bus_req     <= req_n;
      bus_we      <= we_n;
      bus_addr    <= baddr_n;
      bus_wdata   <= wdata_n;
      err_overrun <= ovr_n;
      busy        <= (state_n != IDLE) || req_n;
    end
  end

endmodule
